io_mmio: RTL and testbench

Memory-mapped I/O target for the RISC-V core's 0x8000_0000 address space. It consumes the I/O write strobe, word address and aligned store data produced by the execute-stage store formatter, and the I/O load enable. It provides UART transmit and receive FIFOs, a cycle counter and a retired-instruction counter. Read data is registered and returned one cycle later, matching block-RAM load timing, for the memory-stage load mux.

---
 rtl/io_mmio_pkg.sv | 25 ++
 rtl/io_fifo.sv | 80 ++++++++
 rtl/io_mmio.sv | 152 +++++++++++++++
 tb/tb_io_mmio.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_mmio_pkg
//  Description : Shared constants for the memory-mapped I/O target.
//                Holds the word-address register map and the default FIFO
//                depths.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_mmio_pkg;

    // Word addresses (ALU_out[15:2]) of the mapped registers
    localparam logic [13:0] UART_CTRL = 14'd0;
    localparam logic [13:0] UART_RX   = 14'd1;
    localparam logic [13:0] UART_TX   = 14'd2;
    localparam logic [13:0] CYC_CNT   = 14'd4;
    localparam logic [13:0] INST_CNT  = 14'd5;
    localparam logic [13:0] CNT_RST   = 14'd6;

    // Default FIFO geometry
    localparam int RX_DEPTH_DEFAULT = 4;
    localparam int TX_DEPTH_DEFAULT = 4;
    localparam int UART_WIDTH       = 8;

endpackage : io_mmio_pkg
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_fifo
//  Description : Synchronous FIFO with a combinational head output.
//                Pointers carry one extra wrap bit so full and empty can be
//                told apart without a separate counter. Pushes are ignored
//                while full and pops while empty; there is no pass-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Full when the wrap bits differ but the index bits match
    assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop && !w_empty;

    assign full  = w_full;
    assign empty = w_empty;
    // Present zero when empty so a drained FIFO never shows a stale byte
    assign dout  = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state; wrapping is the natural overflow of AW+1 bits
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers, cleared asynchronously so reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while the slot is not valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule : io_fifo
`default_nettype wire

// File: rtl/io_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : io_mmio
//  Description : Memory-mapped I/O target for the 0x8000_0000 region.
//                Decodes word addresses into UART status, RX pop, TX push,
//                cycle / retired-instruction counters and counter clear.
//                Read data is registered to match block-RAM load latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_mmio
    import io_mmio_pkg::*;
#(
    parameter int RX_DEPTH = RX_DEPTH_DEFAULT,
    parameter int TX_DEPTH = TX_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] IO_Data_addr,
    input  logic [3:0]  IO_WE,
    input  logic        IO_RE,
    input  logic [31:0] Mem_Data_W,
    input  logic        inst_retire,
    output logic [31:0] IO_Data_R,
    output logic [7:0]  tx_data_out,
    output logic        tx_data_out_valid,
    input  logic        tx_data_out_ready,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_data_in_valid,
    output logic        rx_data_in_ready
);

    // Address decode strobes (exact 14-bit compare)
    logic w_sel_ctrl;
    logic w_sel_rx;
    logic w_sel_tx;
    logic w_sel_cyc;
    logic w_sel_inst;
    logic w_sel_clr;

    // FIFO handshakes
    logic       w_rx_push;
    logic       w_rx_pop;
    logic [7:0] w_rx_head;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic [7:0] w_tx_head;
    logic       w_tx_full;
    logic       w_tx_empty;

    // Counters and read-data register
    logic        w_cnt_clr;
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] inst_cnt_q;
    logic [31:0] inst_cnt_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic [31:0] w_rmux;

    // Only the low byte lane carries TX data
    logic w_unused_store_hi;
    assign w_unused_store_hi = ^Mem_Data_W[31:8];

    assign w_sel_ctrl = (IO_Data_addr == UART_CTRL);
    assign w_sel_rx   = (IO_Data_addr == UART_RX);
    assign w_sel_tx   = (IO_Data_addr == UART_TX);
    assign w_sel_cyc  = (IO_Data_addr == CYC_CNT);
    assign w_sel_inst = (IO_Data_addr == INST_CNT);
    assign w_sel_clr  = (IO_Data_addr == CNT_RST);

    assign w_rx_push = rx_data_in_valid && !w_rx_full;
    // The FIFO itself ignores the pop when empty
    assign w_rx_pop  = IO_RE && w_sel_rx;
    assign w_tx_push = IO_WE[0] && w_sel_tx;
    assign w_tx_pop  = !w_tx_empty && tx_data_out_ready;
    assign w_cnt_clr = (|IO_WE) && w_sel_clr;

    io_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (UART_WIDTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .din   (rx_data_in),
        .pop   (w_rx_pop),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    io_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (UART_WIDTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .din   (Mem_Data_W[7:0]),
        .pop   (w_tx_pop),
        .dout  (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    assign rx_data_in_ready  = !w_rx_full;
    assign tx_data_out       = w_tx_head;
    assign tx_data_out_valid = !w_tx_empty;
    assign IO_Data_R         = rdata_q;

    // Counter next-state: clear wins over increment, wrap is natural
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        inst_cnt_d  = inst_cnt_q + {31'd0, inst_retire};
        if (w_cnt_clr) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end
    end

    // Read mux sees pre-edge state; unmapped addresses read as zero
    always_comb begin
        w_rmux = '0;
        if (w_sel_ctrl) begin
            w_rmux = {30'd0, !w_rx_empty, !w_tx_full};
        end else if (w_sel_rx) begin
            w_rmux = {24'd0, w_rx_head};
        end else if (w_sel_cyc) begin
            w_rmux = cycle_cnt_q;
        end else if (w_sel_inst) begin
            w_rmux = inst_cnt_q;
        end
        rdata_d = IO_RE ? w_rmux : rdata_q;
    end

    // Counter and read-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            rdata_q     <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule : io_mmio
`default_nettype wire

// File: tb/tb_io_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_mmio
//  Description : Directed self-checking bench for io_mmio. Expected read
//                data, TX bytes and RX bytes are queued as stimulus is
//                applied and compared as the design produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_mmio;

    localparam int RXD = 4;
    localparam int TXD = 4;

    logic        clk;
    logic        rst;
    logic [13:0] IO_Data_addr;
    logic [3:0]  IO_WE;
    logic        IO_RE;
    logic [31:0] Mem_Data_W;
    logic        inst_retire;
    logic [31:0] IO_Data_R;
    logic [7:0]  tx_data_out;
    logic        tx_data_out_valid;
    logic        tx_data_out_ready;
    logic [7:0]  rx_data_in;
    logic        rx_data_in_valid;
    logic        rx_data_in_ready;

    int n_tests;
    int n_fail;

    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    io_mmio #(
        .RX_DEPTH (RXD),
        .TX_DEPTH (TXD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .IO_Data_addr      (IO_Data_addr),
        .IO_WE             (IO_WE),
        .IO_RE             (IO_RE),
        .Mem_Data_W        (Mem_Data_W),
        .inst_retire       (inst_retire),
        .IO_Data_R         (IO_Data_R),
        .tx_data_out       (tx_data_out),
        .tx_data_out_valid (tx_data_out_valid),
        .tx_data_out_ready (tx_data_out_ready),
        .rx_data_in        (rx_data_in),
        .rx_data_in_valid  (rx_data_in_valid),
        .rx_data_in_ready  (rx_data_in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {30'd0, rx_q.size() != 0, tx_q.size() != TXD};
    endfunction

    task automatic do_read(input logic [13:0] a, input logic [31:0] exp, input string tag);
        rd_q.push_back(exp);
        IO_Data_addr = a;
        IO_RE        = 1'b1;
        tick();
        IO_RE        = 1'b0;
        IO_Data_addr = '0;
        chk(tag, IO_Data_R, rd_q.pop_front());
    endtask

    task automatic do_write(input logic [13:0] a, input logic [3:0] we, input logic [31:0] d);
        IO_Data_addr = a;
        IO_WE        = we;
        Mem_Data_W   = d;
        tick();
        IO_WE        = '0;
        IO_Data_addr = '0;
        Mem_Data_W   = '0;
    endtask

    task automatic rx_read(input string tag);
        logic [31:0] e;
        e = (rx_q.size() != 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
        do_read(14'd1, e, tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        IO_Data_addr = '0; IO_WE = '0; IO_RE = 1'b0; Mem_Data_W = '0;
        inst_retire = 1'b0; tx_data_out_ready = 1'b0;
        rx_data_in = '0; rx_data_in_valid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_rdata", IO_Data_R, 32'd0);
        chk("rst_txv", {31'd0, tx_data_out_valid}, 32'd0);
        chk("rst_txd", {24'd0, tx_data_out}, 32'd0);
        chk("rst_rxrdy", {31'd0, rx_data_in_ready}, 32'd1);

        // Cycle counter after 10 idle cycles
        rst = 1'b0;
        repeat (10) tick();
        do_read(14'd4, 32'd10, "cyc10");
        do_read(14'd0, status_exp(), "status_idle");
        chk("rxrdy_idle", {31'd0, rx_data_in_ready}, 32'd1);

        // Unmapped and aliased reads
        do_read(14'd3, 32'd0, "unmapped3");
        do_read(14'h2004, 32'd0, "alias_cyc");

        // TX write ignored without lane 0 enable
        do_write(14'd2, 4'b0010, 32'h0000_7700);
        chk("tx_we0_ignored", {31'd0, tx_data_out_valid}, 32'd0);

        // TX: two bytes queued then drained
        do_write(14'd2, 4'b0001, 32'hFFFF_FF41); tx_q.push_back(8'h41);
        do_write(14'd2, 4'b0001, 32'h0000_0042); tx_q.push_back(8'h42);
        chk("tx_valid_held", {31'd0, tx_data_out_valid}, 32'd1);
        tx_data_out_ready = 1'b1;
        chk("tx_byte0", {24'd0, tx_data_out}, {24'd0, tx_q.pop_front()});
        tick();
        chk("tx_byte1", {24'd0, tx_data_out}, {24'd0, tx_q.pop_front()});
        tick();
        tx_data_out_ready = 1'b0;
        chk("tx_drained", {31'd0, tx_data_out_valid}, 32'd0);

        // RX: five offered bytes, fifth held upstream
        for (int i = 0; i < 5; i++) begin
            rx_data_in       = 8'h10 + 8'(i);
            rx_data_in_valid = 1'b1;
            if (i < RXD) begin
                chk("rx_ready_fill", {31'd0, rx_data_in_ready}, 32'd1);
                rx_q.push_back(rx_data_in);
            end else begin
                chk("rx_ready_full", {31'd0, rx_data_in_ready}, 32'd0);
            end
            tick();
        end
        rx_data_in_valid = 1'b0;
        do_read(14'd0, status_exp(), "status_rxfull");
        for (int i = 0; i < 5; i++) begin
            rx_read("rx_pop");
        end
        do_read(14'd0, status_exp(), "status_rxempty");

        // Status read in the same cycle as an RX push sees pre-push state
        rd_q.push_back(status_exp());
        rx_data_in = 8'h55; rx_data_in_valid = 1'b1;
        IO_Data_addr = 14'd0; IO_RE = 1'b1;
        tick();
        IO_RE = 1'b0; rx_data_in_valid = 1'b0;
        rx_q.push_back(8'h55);
        chk("status_prepush", IO_Data_R, rd_q.pop_front());
        do_read(14'd0, status_exp(), "status_postpush");
        rx_read("rx_pop55");

        // Retired-instruction counter and clear priority
        inst_retire = 1'b1;
        repeat (7) tick();
        inst_retire = 1'b0;
        do_read(14'd5, 32'd7, "inst7");
        inst_retire = 1'b1;
        do_write(14'd6, 4'b1000, 32'd0);
        inst_retire = 1'b0;
        do_read(14'd5, 32'd0, "inst_clr");
        inst_retire = 1'b1;
        tick();
        inst_retire = 1'b0;
        do_read(14'd5, 32'd1, "inst_one");

        // Cycle counter clear, then one cycle of increment
        do_write(14'd6, 4'b0001, 32'd0);
        do_read(14'd4, 32'd0, "cyc_clr");
        do_read(14'd4, 32'd1, "cyc_after_clr");

        // TX full: write during a pop is dropped
        for (int i = 0; i < TXD; i++) begin
            do_write(14'd2, 4'b0001, 32'hA0 + 32'(i));
            tx_q.push_back(8'hA0 + 8'(i));
        end
        do_read(14'd0, status_exp(), "status_txfull");
        tx_data_out_ready = 1'b1;
        chk("tx_full_head", {24'd0, tx_data_out}, {24'd0, tx_q.pop_front()});
        do_write(14'd2, 4'b0001, 32'h99);
        tx_data_out_ready = 1'b0;
        do_read(14'd0, status_exp(), "status_txdrop");
        tx_data_out_ready = 1'b1;
        for (int i = 0; i < TXD - 1; i++) begin
            chk("tx_drain", {24'd0, tx_data_out}, {24'd0, tx_q.pop_front()});
            tick();
        end
        tx_data_out_ready = 1'b0;
        chk("tx_drop_empty", {31'd0, tx_data_out_valid}, 32'd0);

        // Mid-run reset with half-full FIFOs and live counters
        do_write(14'd2, 4'b0001, 32'h31); tx_q.push_back(8'h31);
        do_write(14'd2, 4'b0001, 32'h32); tx_q.push_back(8'h32);
        rx_data_in_valid = 1'b1;
        rx_data_in = 8'h61; rx_q.push_back(8'h61); tick();
        rx_data_in = 8'h62; rx_q.push_back(8'h62); tick();
        rx_data_in_valid = 1'b0;
        inst_retire = 1'b1; tick(); inst_retire = 1'b0;
        do_read(14'd0, status_exp(), "status_half");
        rst = 1'b1;
        #1;
        tx_q.delete();
        rx_q.delete();
        chk("mid_rst_rdata", IO_Data_R, 32'd0);
        chk("mid_rst_txv", {31'd0, tx_data_out_valid}, 32'd0);
        chk("mid_rst_txd", {24'd0, tx_data_out}, 32'd0);
        chk("mid_rst_rxrdy", {31'd0, rx_data_in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        do_read(14'd4, 32'd0, "post_rst_cyc");
        do_read(14'd5, 32'd0, "post_rst_inst");
        do_read(14'd0, status_exp(), "post_rst_status");
        rx_read("post_rst_rx");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_io_mmio
`default_nettype wire
